// File: rtl/spi_slave_char_engine.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// spi_slave_char_engine
//
// Purpose:
//   SPI responder side of the character engine. Each frame carries one or
//   more characters of 1..16 bits. The external SCK, CS_N and MOSI pins are
//   synchronised into the S_SYSCLK domain, and SCK edges are recovered from
//   the synchronised samples. S_SYSCLK must be at least 8x SCK. The engine
//   supports all four CPOL/CPHA modes, MSB- or LSB-first bit order, and
//   back-to-back characters inside a single CS_N assertion. Toward the core
//   there is a one-deep TX holding register and a valid/ready RX port.
//
// Ports:
//   S_SYSCLK, S_RESET           clock, asynchronous active-high reset
//   S_ENABLE                    0 holds the engine idle (MISO_OE low)
//   S_CPOL, S_CPHA, S_REV       SPI mode and bit order (static while busy)
//   S_CHAR_LEN                  character length minus one
//   S_SPI_CS_N/SCK/MOSI         asynchronous pins from the master
//   S_SPI_MISO, S_SPI_MISO_OE   serial data to the master and its pad enable
//   S_TX_DATA/VALID/READY       next character to send (right-justified)
//   S_RX_DATA/VALID/READY       received character (right-justified)
//   S_RX_OVERRUN                pulse: a character was dropped, RX still full
//   S_TX_UNDERRUN               pulse: a character started with no TX data
//   S_BUSY                      a frame is active
// -----------------------------------------------------------------------------
module spi_slave_char_engine #(
    parameter int          SYNC_STAGES   = 2,
    parameter logic [15:0] UNDERRUN_FILL = 16'hFFFF
) (
    input  logic        S_SYSCLK,
    input  logic        S_RESET,
    input  logic        S_ENABLE,
    input  logic        S_CPOL,
    input  logic        S_CPHA,
    input  logic        S_REV,
    input  logic [3:0]  S_CHAR_LEN,
    input  logic        S_SPI_CS_N,
    input  logic        S_SPI_SCK,
    input  logic        S_SPI_MOSI,
    output logic        S_SPI_MISO,
    output logic        S_SPI_MISO_OE,
    input  logic [15:0] S_TX_DATA,
    input  logic        S_TX_VALID,
    output logic        S_TX_READY,
    output logic [15:0] S_RX_DATA,
    output logic        S_RX_VALID,
    input  logic        S_RX_READY,
    output logic        S_RX_OVERRUN,
    output logic        S_TX_UNDERRUN,
    output logic        S_BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    // Synchroniser chains and the one-sample history used for edge detection
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sck_d;
    logic                   r_cs_d;

    // Frame state and datapath
    state_t      r_state;
    logic        r_busy;
    logic        r_miso;
    logic [15:0] r_tx_sh;
    logic [15:0] r_rx_sh;
    logic [3:0]  r_bitcnt;
    logic        r_presample;
    logic [15:0] r_rx_data;
    logic        r_rx_valid;
    logic        r_rx_overrun;

    // TX holding register
    logic [15:0] r_hold;
    logic        r_tx_ready;
    logic        r_tx_underrun;

    // Combinational helpers
    logic        w_sck;
    logic        w_cs_n;
    logic        w_mosi;
    logic        w_sck_edge;
    logic        w_lead;
    logic        w_trail;
    logic        w_sample;
    logic        w_shift;
    logic        w_cs_fall;
    logic        w_abort;
    logic        w_last;
    logic        w_load;
    logic [3:0]  w_rx_idx;
    logic [15:0] w_rx_next;
    logic [15:0] w_tx_next;
    logic [15:0] w_load_val;

    // Input synchronisers. CS_N resets to the "selected" level so that a pin
    // already held low across reset is not mistaken for a fresh CS_N fall.
    always_ff @(posedge S_SYSCLK or posedge S_RESET) begin
        if (S_RESET) begin
            r_sck_sync  <= {SYNC_STAGES{1'b0}};
            r_cs_sync   <= {SYNC_STAGES{1'b0}};
            r_mosi_sync <= {SYNC_STAGES{1'b0}};
            r_sck_d     <= 1'b0;
            r_cs_d      <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], S_SPI_SCK};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], S_SPI_CS_N};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], S_SPI_MOSI};
            r_sck_d     <= w_sck;
            r_cs_d      <= w_cs_n;
        end
    end

    assign w_sck  = r_sck_sync[SYNC_STAGES-1];
    assign w_cs_n = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    // Leading edge leaves the idle level, trailing edge returns to it.
    assign w_sck_edge = w_sck ^ r_sck_d;
    assign w_lead     = w_sck_edge & (w_sck != S_CPOL);
    assign w_trail    = w_sck_edge & (w_sck == S_CPOL);
    assign w_sample   = S_CPHA ? w_trail : w_lead;
    assign w_shift    = S_CPHA ? w_lead  : w_trail;

    assign w_cs_fall  = ~w_cs_n & r_cs_d;
    assign w_abort    = w_cs_n | ~S_ENABLE;
    assign w_last     = (r_bitcnt == S_CHAR_LEN);
    assign w_load     = (r_state == ST_LOAD) && !w_abort;
    assign w_load_val = r_tx_ready ? UNDERRUN_FILL : r_hold;
    assign w_tx_next  = S_REV ? {r_tx_sh[14:0], 1'b0} : {1'b0, r_tx_sh[15:1]};
    assign w_rx_idx   = S_REV ? (S_CHAR_LEN - r_bitcnt) : r_bitcnt;

    // Receive register with the current MOSI bit dropped into its final position
    always_comb begin
        w_rx_next           = r_rx_sh;
        w_rx_next[w_rx_idx] = w_mosi;
    end

    // Frame FSM with the shift datapath and RX handshake.
    // r_presample is set at each character start: a shift edge seen before the
    // first sample edge of a character must not advance the TX register, since
    // bit 0 is already on MISO (CPHA=1 first leading edge, or the trailing edge
    // that closes the previous character when CPHA=0).
    always_ff @(posedge S_SYSCLK or posedge S_RESET) begin
        if (S_RESET) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_miso       <= 1'b0;
            r_tx_sh      <= 16'h0000;
            r_rx_sh      <= 16'h0000;
            r_bitcnt     <= 4'd0;
            r_presample  <= 1'b0;
            r_rx_data    <= 16'h0000;
            r_rx_valid   <= 1'b0;
            r_rx_overrun <= 1'b0;
        end else begin
            r_rx_overrun <= 1'b0;
            if (r_rx_valid && S_RX_READY) begin
                r_rx_valid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    r_miso <= 1'b0;
                    if (S_ENABLE && w_cs_fall) begin
                        r_state <= ST_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_miso  <= 1'b0;
                    end else begin
                        r_tx_sh     <= w_load_val;
                        r_miso      <= S_REV ? w_load_val[S_CHAR_LEN] : w_load_val[0];
                        r_rx_sh     <= 16'h0000;
                        r_bitcnt    <= 4'd0;
                        r_presample <= 1'b1;
                        r_state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_miso  <= 1'b0;
                    end else if (w_sample) begin
                        r_rx_sh     <= w_rx_next;
                        r_presample <= 1'b0;
                        if (w_last) begin
                            // Deliver unless the core still holds the previous char.
                            if (!r_rx_valid || S_RX_READY) begin
                                r_rx_data  <= w_rx_next;
                                r_rx_valid <= 1'b1;
                            end else begin
                                r_rx_overrun <= 1'b1;
                            end
                            r_state <= ST_LOAD;
                        end else begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end
                    end else if (w_shift && !r_presample) begin
                        r_tx_sh <= w_tx_next;
                        r_miso  <= S_REV ? w_tx_next[S_CHAR_LEN] : w_tx_next[0];
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_miso  <= 1'b0;
                end
            endcase
        end
    end

    // One-deep TX holding register: filled by the core, drained at char start
    always_ff @(posedge S_SYSCLK or posedge S_RESET) begin
        if (S_RESET) begin
            r_hold        <= 16'h0000;
            r_tx_ready    <= 1'b1;
            r_tx_underrun <= 1'b0;
        end else begin
            r_tx_underrun <= 1'b0;
            if (w_load) begin
                if (r_tx_ready) begin
                    r_tx_underrun <= 1'b1;
                end else begin
                    r_tx_ready <= 1'b1;
                end
            end
            // Only possible while empty, so it never collides with a drain.
            if (S_TX_VALID && r_tx_ready) begin
                r_hold     <= S_TX_DATA;
                r_tx_ready <= 1'b0;
            end
        end
    end

    assign S_SPI_MISO    = r_miso;
    assign S_SPI_MISO_OE = r_busy;
    assign S_BUSY        = r_busy;
    assign S_TX_READY    = r_tx_ready;
    assign S_RX_DATA     = r_rx_data;
    assign S_RX_VALID    = r_rx_valid;
    assign S_RX_OVERRUN  = r_rx_overrun;
    assign S_TX_UNDERRUN = r_tx_underrun;

endmodule

// File: tb/tb_spi_slave_char_engine.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_spi_slave_char_engine
//
// Directed bench for spi_slave_char_engine. A behavioural SPI master drives
// SCK at 1/16 of the system clock and captures MISO; expected values are the
// hand-computed constants from each scenario.
// -----------------------------------------------------------------------------
module tb_spi_slave_char_engine;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        cpol;
    logic        cpha;
    logic        rev;
    logic [3:0]  char_len;
    logic        cs_n;
    logic        sck;
    logic        mosi;
    logic        miso;
    logic        miso_oe;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        rx_overrun;
    logic        tx_underrun;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int n_under = 0;
    int n_over  = 0;

    spi_slave_char_engine #(
        .SYNC_STAGES   (2),
        .UNDERRUN_FILL (16'hFFFF)
    ) dut (
        .S_SYSCLK      (clk),
        .S_RESET       (rst),
        .S_ENABLE      (enable),
        .S_CPOL        (cpol),
        .S_CPHA        (cpha),
        .S_REV         (rev),
        .S_CHAR_LEN    (char_len),
        .S_SPI_CS_N    (cs_n),
        .S_SPI_SCK     (sck),
        .S_SPI_MOSI    (mosi),
        .S_SPI_MISO    (miso),
        .S_SPI_MISO_OE (miso_oe),
        .S_TX_DATA     (tx_data),
        .S_TX_VALID    (tx_valid),
        .S_TX_READY    (tx_ready),
        .S_RX_DATA     (rx_data),
        .S_RX_VALID    (rx_valid),
        .S_RX_READY    (rx_ready),
        .S_RX_OVERRUN  (rx_overrun),
        .S_TX_UNDERRUN (tx_underrun),
        .S_BUSY        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count single-cycle status pulses
    always @(posedge clk) begin
        if (tx_underrun) n_under = n_under + 1;
        if (rx_overrun)  n_over  = n_over + 1;
    end

    // Hard stop if something wedges the run
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic half();
        repeat (8) @(negedge clk);
    endtask

    task automatic set_mode(input logic p, input logic h, input logic r, input logic [3:0] l);
        cpol     = p;
        cpha     = h;
        rev      = r;
        char_len = l;
        sck      = p;
        half();
    endtask

    task automatic load_tx(input logic [15:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Master side of one character (or the first nbits of it)
    task automatic spi_char(input logic [15:0] mo, input int nbits, output logic [15:0] mi);
        int idx;
        mi = 16'h0000;
        for (int k = 0; k < nbits; k++) begin
            idx = rev ? (int'(char_len) - k) : k;
            if (!cpha) begin
                mosi = mo[idx];
                half();
                sck = ~cpol;
                mi[idx] = miso;
                half();
                sck = cpol;
            end else begin
                sck = ~cpol;
                mosi = mo[idx];
                half();
                sck = cpol;
                mi[idx] = miso;
                half();
            end
        end
    endtask

    task automatic wait_rx(input string name);
        int n;
        n = 0;
        while (rx_valid !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rx_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_rx_valid: rx_valid=%b after %0d cycles, required 1", name, rx_valid, n);
        end
    endtask

    task automatic accept_rx(input string name);
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_rx_accept: rx_valid=%b required 0", name, rx_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks += 8;
        if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b required 0", miso); end
        if (miso_oe !== 1'b0) begin errors++; $display("FAIL reset_miso_oe: got %b required 0", miso_oe); end
        if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b required 1", tx_ready); end
        if (rx_data !== 16'h0000) begin errors++; $display("FAIL reset_rx_data: got %h required 0000", rx_data); end
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b required 0", rx_valid); end
        if (rx_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b required 0", rx_overrun); end
        if (tx_underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b required 0", tx_underrun); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    endtask

    task automatic test_mode0();
        logic [15:0] mi;
        int u0;
        set_mode(1'b0, 1'b0, 1'b1, 4'd7);
        load_tx(16'h00A5);
        checks++;
        if (tx_ready !== 1'b0) begin errors++; $display("FAIL mode0_tx_ready_full: got %b required 0", tx_ready); end
        u0 = n_under;
        cs_n = 1'b0;
        half();
        checks += 3;
        if (busy !== 1'b1) begin errors++; $display("FAIL mode0_busy: got %b required 1", busy); end
        if (miso_oe !== 1'b1) begin errors++; $display("FAIL mode0_miso_oe: got %b required 1", miso_oe); end
        if (n_under - u0 !== 0) begin errors++; $display("FAIL mode0_no_underrun: got %0d pulses required 0", n_under - u0); end
        spi_char(16'h003C, 8, mi);
        wait_rx("mode0");
        checks += 3;
        if (mi !== 16'h00A5) begin errors++; $display("FAIL mode0_miso: got %h required 00a5", mi); end
        if (rx_data !== 16'h003C) begin errors++; $display("FAIL mode0_rx_data: got %h required 003c", rx_data); end
        if (tx_ready !== 1'b1) begin errors++; $display("FAIL mode0_tx_ready_empty: got %b required 1", tx_ready); end
        half();
        cs_n = 1'b1;
        half();
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL mode0_busy_end: got %b required 0", busy); end
        if (miso !== 1'b0) begin errors++; $display("FAIL mode0_miso_idle: got %b required 0", miso); end
        accept_rx("mode0");
    endtask

    task automatic test_mode3();
        logic [15:0] mi;
        set_mode(1'b1, 1'b1, 1'b0, 4'd15);
        load_tx(16'h1234);
        cs_n = 1'b0;
        half();
        spi_char(16'hBEEF, 16, mi);
        wait_rx("mode3");
        checks += 2;
        if (mi !== 16'h1234) begin errors++; $display("FAIL mode3_miso: got %h required 1234", mi); end
        if (rx_data !== 16'hBEEF) begin errors++; $display("FAIL mode3_rx_data: got %h required beef", rx_data); end
        cs_n = 1'b1;
        half();
        accept_rx("mode3");
    endtask

    task automatic test_underrun();
        logic [15:0] mi;
        int u0;
        set_mode(1'b0, 1'b1, 1'b1, 4'd7);
        u0 = n_under;
        cs_n = 1'b0;
        half();
        checks++;
        if (n_under - u0 !== 1) begin errors++; $display("FAIL underrun_pulse: got %0d pulses required 1", n_under - u0); end
        spi_char(16'h0081, 8, mi);
        wait_rx("underrun");
        checks += 2;
        if (mi !== 16'h00FF) begin errors++; $display("FAIL underrun_miso: got %h required 00ff", mi); end
        if (rx_data !== 16'h0081) begin errors++; $display("FAIL underrun_rx_data: got %h required 0081", rx_data); end
        cs_n = 1'b1;
        half();
        accept_rx("underrun");
    endtask

    task automatic test_back_to_back();
        logic [15:0] mi;
        int o0;
        set_mode(1'b0, 1'b0, 1'b0, 4'd7);
        o0 = n_over;
        cs_n = 1'b0;
        half();
        spi_char(16'h005A, 8, mi);
        wait_rx("b2b_first");
        checks++;
        if (n_over - o0 !== 0) begin errors++; $display("FAIL b2b_no_overrun_first: got %0d pulses required 0", n_over - o0); end
        spi_char(16'h00C3, 8, mi);
        half();
        checks += 3;
        if (rx_data !== 16'h005A) begin errors++; $display("FAIL b2b_rx_kept: got %h required 005a", rx_data); end
        if (rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_rx_valid: got %b required 1", rx_valid); end
        if (n_over - o0 !== 1) begin errors++; $display("FAIL b2b_overrun_pulse: got %0d pulses required 1", n_over - o0); end
        cs_n = 1'b1;
        half();
        accept_rx("b2b");
    endtask

    task automatic test_abort();
        logic [15:0] mi;
        set_mode(1'b0, 1'b0, 1'b1, 4'd7);
        cs_n = 1'b0;
        half();
        spi_char(16'h00F0, 5, mi);
        half();
        cs_n = 1'b1;
        half();
        checks += 4;
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL abort_rx_valid: got %b required 0", rx_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b required 0", busy); end
        if (miso_oe !== 1'b0) begin errors++; $display("FAIL abort_miso_oe: got %b required 0", miso_oe); end
        if (miso !== 1'b0) begin errors++; $display("FAIL abort_miso: got %b required 0", miso); end
        load_tx(16'h0096);
        cs_n = 1'b0;
        half();
        spi_char(16'h0069, 8, mi);
        wait_rx("abort_next");
        checks += 2;
        if (mi !== 16'h0096) begin errors++; $display("FAIL abort_next_miso: got %h required 0096", mi); end
        if (rx_data !== 16'h0069) begin errors++; $display("FAIL abort_next_rx_data: got %h required 0069", rx_data); end
        cs_n = 1'b1;
        half();
        accept_rx("abort_next");
    endtask

    task automatic test_reset_mid();
        logic [15:0] mi;
        set_mode(1'b0, 1'b0, 1'b1, 4'd7);
        load_tx(16'h0011);
        cs_n = 1'b0;
        half();
        spi_char(16'h00AA, 3, mi);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks += 5;
        if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b required 0", busy); end
        if (miso_oe !== 1'b0) begin errors++; $display("FAIL rstmid_miso_oe: got %b required 0", miso_oe); end
        if (miso !== 1'b0) begin errors++; $display("FAIL rstmid_miso: got %b required 0", miso); end
        if (tx_ready !== 1'b1) begin errors++; $display("FAIL rstmid_tx_ready: got %b required 1", tx_ready); end
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_rx_valid: got %b required 0", rx_valid); end
        rst = 1'b0;
        // CS_N still low: the frame must not resume without a new fall.
        spi_char(16'h00AA, 4, mi);
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_no_resume: busy=%b required 0", busy); end
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_rx: rx_valid=%b required 0", rx_valid); end
        half();
        cs_n = 1'b1;
        half();
        load_tx(16'h004E);
        cs_n = 1'b0;
        half();
        spi_char(16'h00E4, 8, mi);
        wait_rx("rstmid_next");
        checks += 2;
        if (mi !== 16'h004E) begin errors++; $display("FAIL rstmid_next_miso: got %h required 004e", mi); end
        if (rx_data !== 16'h00E4) begin errors++; $display("FAIL rstmid_next_rx_data: got %h required 00e4", rx_data); end
        cs_n = 1'b1;
        half();
        accept_rx("rstmid_next");
    endtask

    initial begin
        rst      = 1'b1;
        enable   = 1'b1;
        cpol     = 1'b0;
        cpha     = 1'b0;
        rev      = 1'b1;
        char_len = 4'd7;
        cs_n     = 1'b1;
        sck      = 1'b0;
        mosi     = 1'b0;
        tx_data  = 16'h0000;
        tx_valid = 1'b0;
        rx_ready = 1'b0;

        test_reset();
        test_mode0();
        test_mode3();
        test_underrun();
        test_back_to_back();
        test_abort();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
